// File: rtl/sensor_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sensor_scanner
// Brief    : Round-robin 4-channel analog mux scanner with settle, averaging
//            and dwell-held result presentation for change-detect downstream.
// Revision : 1.0
// ============================================================================
module sensor_scanner #(
  parameter int SETTLE   = 4,
  parameter int AVG_LOG2 = 2,
  parameter int DWELL    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] adc_data,
  input  logic       adc_valid,
  output logic [1:0] ch_sel,
  output logic [7:0] r0,
  output logic [1:0] check,
  output logic       out_valid,
  output logic       scan_done
);

  localparam int c_SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int c_DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int c_ACC_W = 8 + AVG_LOG2;
  localparam int c_SMP_W = AVG_LOG2 + 1;

  localparam logic [c_SET_W-1:0] c_SET_LOAD = c_SET_W'(SETTLE - 1);
  localparam logic [c_DW_W-1:0]  c_DW_LOAD  = c_DW_W'(DWELL - 1);
  localparam logic [c_SMP_W-1:0] c_SMP_LAST = c_SMP_W'((1 << AVG_LOG2) - 1);

  localparam logic [1:0] c_S_IDLE   = 2'd0;
  localparam logic [1:0] c_S_SETTLE = 2'd1;
  localparam logic [1:0] c_S_ACCUM  = 2'd2;
  localparam logic [1:0] c_S_HOLD   = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_next;
  logic [c_SET_W-1:0] r_set_cnt;
  logic [c_DW_W-1:0]  r_dw_cnt;
  logic [c_SMP_W-1:0] r_smp_cnt;
  logic [c_ACC_W-1:0] r_acc;
  logic [1:0]         r_ptr;
  logic [7:0]         r_r0;
  logic [1:0]         r_check;
  logic               r_scan_done;

  logic               w_set_zero;
  logic               w_dw_zero;
  logic               w_last_smp;
  logic [c_ACC_W-1:0] w_sum;

  assign w_set_zero = (r_set_cnt == '0);
  assign w_dw_zero  = (r_dw_cnt == '0);
  assign w_last_smp = adc_valid && (r_smp_cnt == c_SMP_LAST);
  // Width 8+AVG_LOG2 holds 2^AVG_LOG2 * 255, so this sum never wraps.
  assign w_sum      = r_acc + c_ACC_W'(adc_data);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_S_IDLE:   if (en) w_next = c_S_SETTLE;
      c_S_SETTLE: if (w_set_zero) w_next = c_S_ACCUM;
      c_S_ACCUM:  if (w_last_smp) w_next = c_S_HOLD;
      c_S_HOLD:   if (w_dw_zero) w_next = en ? c_S_SETTLE : c_S_IDLE;
      default:    w_next = c_S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    out_valid = 1'b0;
    if (r_state == c_S_HOLD) out_valid = 1'b1;
  end

  // Counters, accumulator, channel pointer and held result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_set_cnt   <= '0;
      r_dw_cnt    <= '0;
      r_smp_cnt   <= '0;
      r_acc       <= '0;
      r_ptr       <= '0;
      r_r0        <= '0;
      r_check     <= '0;
      r_scan_done <= 1'b0;
    end else begin
      r_scan_done <= 1'b0;
      case (r_state)
        c_S_IDLE: begin
          if (en) r_set_cnt <= c_SET_LOAD;
        end
        c_S_SETTLE: begin
          if (w_set_zero) begin
            r_acc     <= '0;
            r_smp_cnt <= '0;
          end else begin
            r_set_cnt <= r_set_cnt - 1'b1;
          end
        end
        c_S_ACCUM: begin
          if (w_last_smp) begin
            r_r0     <= 8'(w_sum >> AVG_LOG2);
            r_check  <= r_ptr;
            r_dw_cnt <= c_DW_LOAD;
          end else if (adc_valid) begin
            r_acc     <= w_sum;
            r_smp_cnt <= r_smp_cnt + 1'b1;
          end
        end
        c_S_HOLD: begin
          if (w_dw_zero) begin
            r_ptr       <= r_ptr + 1'b1;
            r_scan_done <= (r_ptr == 2'd3);
            if (en) r_set_cnt <= c_SET_LOAD;
          end else begin
            r_dw_cnt <= r_dw_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ch_sel    = r_ptr;
  assign r0        = r_r0;
  assign check     = r_check;
  assign scan_done = r_scan_done;

endmodule
`default_nettype wire

// File: tb/tb_sensor_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sensor_scanner
// Brief    : Scoreboard bench; two scanner instances (default and minimal
//            parameters) driven open-loop from a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_sensor_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_s     [2];
  logic       en_s        [2];
  logic [7:0] adc_data_s  [2];
  logic       adc_valid_s [2];
  logic [1:0] ch_sel_s    [2];
  logic [7:0] r0_s        [2];
  logic [1:0] check_s     [2];
  logic       ov_s        [2];
  logic       sd_s        [2];

  sensor_scanner u_dut0 (
    .clk(clk), .rst_n(rst_n_s[0]), .en(en_s[0]), .adc_data(adc_data_s[0]),
    .adc_valid(adc_valid_s[0]), .ch_sel(ch_sel_s[0]), .r0(r0_s[0]),
    .check(check_s[0]), .out_valid(ov_s[0]), .scan_done(sd_s[0])
  );

  sensor_scanner #(.SETTLE(2), .AVG_LOG2(0), .DWELL(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n_s[1]), .en(en_s[1]), .adc_data(adc_data_s[1]),
    .adc_valid(adc_valid_s[1]), .ch_sel(ch_sel_s[1]), .r0(r0_s[1]),
    .check(check_s[1]), .out_valid(ov_s[1]), .scan_done(sd_s[1])
  );

  typedef struct {
    int val;
    int ch;
    int cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   ptr [2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int p_set(input int k); return (k == 0) ? 4 : 2; endfunction
  function automatic int p_avg(input int k); return (k == 0) ? 2 : 0; endfunction
  function automatic int p_dw (input int k); return (k == 0) ? 4 : 3; endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Ignored-input noise: random adc_valid/data and, optionally, random en.
  task automatic junk(input int k, input bit en_rand);
    adc_valid_s[k] = 1'($urandom_range(0, 1));
    adc_data_s[k]  = 8'($urandom);
    if (en_rand) en_s[k] = 1'($urandom_range(0, 1));
  endtask

  task automatic start(input int k);
    junk(k, 0);
    en_s[k] = 1'b1;
    step();
  endtask

  task automatic idle(input int k, input int n);
    repeat (n) begin
      junk(k, 0);
      en_s[k] = 1'b0;
      step();
    end
  endtask

  // One channel transaction, called just after the edge entering SETTLE.
  task automatic run_chan(input int k, input bit rnd, input int base, input int stp,
                          input bit fixgap, input int gap, input bit s_junk,
                          input bit next_en, input int stop_after);
    int   n;
    int   sum;
    int   d;
    int   g;
    exp_t e;
    n   = 1 << p_avg(k);
    sum = 0;
    for (int j = 0; j < p_set(k); j++) begin
      junk(k, 1);
      if (s_junk) begin
        adc_valid_s[k] = 1'b1;
        adc_data_s[k]  = 8'd200;
      end
      step();
    end
    for (int i = 0; i < n; i++) begin
      if (fixgap) g = (i == 0) ? 0 : gap;
      else        g = $urandom_range(0, gap);
      repeat (g) begin
        junk(k, 1);
        adc_valid_s[k] = 1'b0;
        step();
      end
      d = rnd ? $urandom_range(0, 255) : ((base + i * stp) & 255);
      junk(k, 1);
      adc_valid_s[k] = 1'b1;
      adc_data_s[k]  = 8'(d);
      sum += d;
      step();
      if (stop_after == i + 1) return;
    end
    e.val = sum / n;
    e.ch  = ptr[k];
    e.cyc = cyc;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
    for (int j = 0; j < p_dw(k); j++) begin
      junk(k, 1);
      if (j == p_dw(k) - 1) en_s[k] = next_en;
      step();
    end
    ptr[k] = (ptr[k] + 1) % 4;
  endtask

  task automatic mon(input int k);
    bit   prev;
    int   run;
    int   last_r0;
    int   last_ch;
    exp_t e;
    prev = 0; run = 0; last_r0 = 0; last_ch = 0;
    forever begin
      @(negedge clk);
      if (!rst_n_s[k]) begin
        prev = 0; run = 0; last_r0 = 0; last_ch = 0;
        continue;
      end
      if (ov_s[k] && !prev) begin
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result dut%0d: r0=%0d check=%0d, none pending", k, r0_s[k], check_s[k]);
        end else begin
          if (k == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk($sformatf("r0 dut%0d", k), int'(r0_s[k]), e.val);
          chk($sformatf("check dut%0d", k), int'(check_s[k]), e.ch);
          chk($sformatf("rise_cycle dut%0d", k), cyc, e.cyc);
        end
        last_r0 = int'(r0_s[k]);
        last_ch = int'(check_s[k]);
        run = 1;
      end else if (ov_s[k]) begin
        run++;
      end
      if (ov_s[k]) begin
        chk($sformatf("ch_sel_in_hold dut%0d", k), int'(ch_sel_s[k]), last_ch);
        chk($sformatf("scan_done_in_hold dut%0d", k), int'(sd_s[k]), 0);
      end else begin
        chk($sformatf("r0_held dut%0d", k), int'(r0_s[k]), last_r0);
        chk($sformatf("check_held dut%0d", k), int'(check_s[k]), last_ch);
        if (prev) begin
          chk($sformatf("dwell_len dut%0d", k), run, p_dw(k));
          chk($sformatf("scan_done dut%0d", k), int'(sd_s[k]), (last_ch == 3) ? 1 : 0);
          chk($sformatf("ch_sel_next dut%0d", k), int'(ch_sel_s[k]), (last_ch + 1) % 4);
        end else if (sd_s[k]) begin
          chk($sformatf("stray_scan_done dut%0d", k), 1, 0);
        end
      end
      prev = ov_s[k];
    end
  endtask

  initial mon(0);
  initial mon(1);

  initial begin
    bit ne;
    for (int k = 0; k < 2; k++) begin
      rst_n_s[k] = 1'b0; en_s[k] = 1'b0; adc_valid_s[k] = 1'b0;
      adc_data_s[k] = 8'd0; ptr[k] = 0;
    end
    repeat (3) step();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_ch_sel dut%0d", k), int'(ch_sel_s[k]), 0);
      chk($sformatf("reset_r0 dut%0d", k), int'(r0_s[k]), 0);
      chk($sformatf("reset_check dut%0d", k), int'(check_s[k]), 0);
      chk($sformatf("reset_out_valid dut%0d", k), int'(ov_s[k]), 0);
      chk($sformatf("reset_scan_done dut%0d", k), int'(sd_s[k]), 0);
    end
    rst_n_s[0] = 1'b1;
    rst_n_s[1] = 1'b1;
    step();

    // Default-parameter instance: directed scenarios, then random channels.
    start(0);
    run_chan(0, 0, 10, 1, 0, 0, 0, 1, 0);
    repeat (3) run_chan(0, 1, 0, 0, 0, 2, 0, 1, 0);
    run_chan(0, 0, 0,   0, 0, 1, 0, 1, 0);
    run_chan(0, 0, 1,   0, 0, 1, 0, 1, 0);
    run_chan(0, 0, 254, 0, 0, 1, 0, 1, 0);
    run_chan(0, 0, 255, 0, 0, 1, 0, 1, 0);
    run_chan(0, 0, 40,  0, 0, 0, 1, 1, 0);
    run_chan(0, 0, 100, 0, 1, 3, 0, 0, 0);
    idle(0, 6);
    start(0);
    for (int i = 0; i < 12; i++) begin
      ne = ($urandom_range(0, 3) != 0);
      run_chan(0, 1, 0, 0, 0, 3, 1'($urandom_range(0, 1)), ne, 0);
      if (!ne) begin
        idle(0, $urandom_range(1, 5));
        start(0);
      end
    end
    while (ptr[0] != 2) run_chan(0, 1, 0, 0, 0, 2, 0, 1, 0);
    run_chan(0, 0, 77, 3, 0, 0, 0, 1, 2);
    #2;
    rst_n_s[0] = 1'b0;
    #1;
    chk("async_reset_ch_sel", int'(ch_sel_s[0]), 0);
    chk("async_reset_r0", int'(r0_s[0]), 0);
    chk("async_reset_check", int'(check_s[0]), 0);
    chk("async_reset_out_valid", int'(ov_s[0]), 0);
    chk("async_reset_scan_done", int'(sd_s[0]), 0);
    ptr[0] = 0;
    en_s[0] = 1'b1;
    adc_valid_s[0] = 1'b0;
    step();
    step();
    rst_n_s[0] = 1'b1;
    chk("ch_sel_after_reset", int'(ch_sel_s[0]), 0);
    step();
    run_chan(0, 1, 0, 0, 0, 2, 0, 1, 0);
    run_chan(0, 1, 0, 0, 0, 2, 0, 0, 0);
    idle(0, 4);

    // Minimal-parameter instance: single-sample pass-through.
    start(1);
    for (int i = 0; i < 16; i++) begin
      ne = ($urandom_range(0, 3) != 0);
      run_chan(1, 1, 0, 0, 0, 3, 1'($urandom_range(0, 1)), ne, 0);
      if (!ne) begin
        idle(1, $urandom_range(1, 4));
        start(1);
      end
    end
    run_chan(1, 1, 0, 0, 0, 2, 0, 0, 0);
    idle(1, 4);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
